// File: rtl/alu_pipeline_hs_if.sv
// Handshake bundle for alu_pipeline_hs: an input transaction channel
// (operands plus two opcodes), a result channel and status outputs.
interface alu_pipeline_hs_if #(
  parameter int DWIDTH = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DWIDTH-1:0] op1_i;
  logic [DWIDTH-1:0] op2_i;
  logic [2:0]        sel_a_i;
  logic [2:0]        sel_b_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DWIDTH-1:0] res_o;
  logic              zero_o;
  logic              neg_o;
  logic [1:0]        occupancy_o;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_valid_i, op1_i, op2_i, sel_a_i, sel_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, zero_o, neg_o, occupancy_o
  );

  // Pipeline side
  modport slave (
    input  in_valid_i, op1_i, op2_i, sel_a_i, sel_b_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, zero_o, neg_o, occupancy_o
  );
endinterface

// File: rtl/alu_pipeline_hs.sv
// Elastic three-stage ALU pipeline. Stage A computes r1 = op1 OPA op2,
// stage B computes r2 = r1 OPB op1 with op1 carried alongside r1.
// Every stage has a valid bit; a stage accepts new contents whenever the
// stage downstream of it can move, so bubbles are squeezed out under stall.
module alu_pipeline_hs #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  alu_pipeline_hs_if.slave  bus
);

  localparam int SHW = $clog2(DWIDTH);

  // Shared ALU used by both compute stages; arithmetic wraps modulo 2^DWIDTH.
  function automatic logic [DWIDTH-1:0] alu_f(
    input logic [2:0]        sel,
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b
  );
    logic [DWIDTH-1:0] y;
    y = {DWIDTH{1'b0}};
    case (sel)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = a << b[SHW-1:0];
      3'b110:  y = a >> b[SHW-1:0];
      3'b111:  y = a;
      default: y = a;
    endcase
    return y;
  endfunction

  // Stage valid bits
  logic r_v0, r_v1, r_v2;

  // S0: captured input transaction
  logic [DWIDTH-1:0] r_op1_s0, r_op2_s0;
  logic [2:0]        r_sel_a_s0, r_sel_b_s0;

  // S1: stage-A result with op1 forwarded for stage B
  logic [DWIDTH-1:0] r_r1_s1, r_op1_s1;
  logic [2:0]        r_sel_b_s1;

  // S2: final result and flags
  logic [DWIDTH-1:0] r_res_s2;
  logic              r_zero_s2, r_neg_s2;

  logic              w_rdy0, w_rdy1, w_rdy2;
  logic [DWIDTH-1:0] w_r1, w_r2;

  // Ready chain and stage ALUs; input acceptance is blocked during reset or flush
  always_comb begin
    w_rdy2         = !r_v2 || bus.out_ready_i;
    w_rdy1         = !r_v1 || w_rdy2;
    w_rdy0         = !r_v0 || w_rdy1;
    w_r1           = alu_f(r_sel_a_s0, r_op1_s0, r_op2_s0);
    w_r2           = alu_f(r_sel_b_s1, r_r1_s1, r_op1_s1);
    bus.in_ready_o = w_rdy0 && rst && !flush_i;
  end

  assign bus.out_valid_o = r_v2;
  assign bus.res_o       = r_res_s2;
  assign bus.zero_o      = r_zero_s2;
  assign bus.neg_o       = r_neg_s2;
  assign bus.occupancy_o = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_v2};

  // Pipeline state: valid bits always follow upstream on a move, data only when upstream is valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_op1_s0   <= {DWIDTH{1'b0}};
      r_op2_s0   <= {DWIDTH{1'b0}};
      r_sel_a_s0 <= 3'b000;
      r_sel_b_s0 <= 3'b000;
      r_r1_s1    <= {DWIDTH{1'b0}};
      r_op1_s1   <= {DWIDTH{1'b0}};
      r_sel_b_s1 <= 3'b000;
      r_res_s2   <= {DWIDTH{1'b0}};
      r_zero_s2  <= 1'b0;
      r_neg_s2   <= 1'b0;
    end else if (flush_i) begin
      // Drop in-flight work; data registers keep their stale contents
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_res_s2  <= w_r2;
          r_zero_s2 <= (w_r2 == {DWIDTH{1'b0}});
          r_neg_s2  <= w_r2[DWIDTH-1];
        end
      end
      if (w_rdy1) begin
        r_v1 <= r_v0;
        if (r_v0) begin
          r_r1_s1    <= w_r1;
          r_op1_s1   <= r_op1_s0;
          r_sel_b_s1 <= r_sel_b_s0;
        end
      end
      if (w_rdy0) begin
        r_v0 <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          r_op1_s0   <= bus.op1_i;
          r_op2_s0   <= bus.op2_i;
          r_sel_a_s0 <= bus.sel_a_i;
          r_sel_b_s0 <= bus.sel_b_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipeline_hs.sv
// Directed bench for alu_pipeline_hs (DWIDTH=8). Inputs are driven and
// outputs sampled on the falling clock edge; expected results are
// hand-computed constants placed in small vector tables.
module tb_alu_pipeline_hs;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic clk;
  logic rst;
  logic flush_i;

  int n_checks;
  int n_errors;

  logic [7:0] v_op1 [8];
  logic [7:0] v_op2 [8];
  logic [2:0] v_sa  [8];
  logic [2:0] v_sb  [8];
  logic [7:0] v_exp [8];

  alu_pipeline_hs_if #(.DWIDTH(8)) bus ();

  alu_pipeline_hs #(.DWIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sa, input logic [2:0] sb);
    bus.in_valid_i = 1'b1;
    bus.op1_i      = a;
    bus.op2_i      = b;
    bus.sel_a_i    = sa;
    bus.sel_b_i    = sb;
  endtask

  // Stream n table entries back to back into an empty pipe with out_ready=1
  // and check each result appears exactly two edges after its accept edge.
  task automatic run_vec(input string tag, input int n);
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        chk({tag, "_vld"},  {31'd0, bus.out_valid_o}, 32'd1);
        chk({tag, "_res"},  {24'd0, bus.res_o},       {24'd0, v_exp[j-3]});
        chk({tag, "_zero"}, {31'd0, bus.zero_o},      {31'd0, (v_exp[j-3] == 8'h00)});
        chk({tag, "_neg"},  {31'd0, bus.neg_o},       {31'd0, v_exp[j-3][7]});
      end else if (j >= 1 && j - 1 < 1) begin
        chk({tag, "_lat1"}, {31'd0, bus.out_valid_o}, 32'd0);
      end else if (j == 2) begin
        chk({tag, "_lat2"}, {31'd0, bus.out_valid_o}, 32'd0);
      end
      if (j < n) begin
        chk({tag, "_rdy"}, {31'd0, bus.in_ready_o}, 32'd1);
        drive(v_op1[j], v_op2[j], v_sa[j], v_sb[j]);
      end else begin
        bus.in_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_drain"}, {31'd0, bus.out_valid_o}, 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b0;
    flush_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.op1_i      = 8'h00;
    bus.op2_i      = 8'h00;
    bus.sel_a_i    = 3'b000;
    bus.sel_b_i    = 3'b000;
    bus.out_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst_res", {24'd0, bus.res_o}, 32'd0);
    chk("rst_occ", {30'd0, bus.occupancy_o}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready_o}, 32'd0);
    rst = 1'b1;

    // 1: basic 5+3=8, 8-5=3
    v_op1[0] = 8'h05; v_op2[0] = 8'h03; v_sa[0] = OP_ADD; v_sb[0] = OP_SUB; v_exp[0] = 8'h03;
    run_vec("basic", 1);

    // 2: stream op1=i, op2=2i, ADD then XOR -> (3i)^i
    for (int i = 0; i < 8; i++) begin
      v_op1[i] = 8'(i);
      v_op2[i] = 8'(2 * i);
      v_sa[i]  = OP_ADD;
      v_sb[i]  = OP_XOR;
    end
    v_exp[0] = 8'h00; v_exp[1] = 8'h02; v_exp[2] = 8'h04; v_exp[3] = 8'h0A;
    v_exp[4] = 8'h08; v_exp[5] = 8'h0A; v_exp[6] = 8'h14; v_exp[7] = 8'h12;
    run_vec("stream", 8);

    // 3: backpressure, 5 transactions op1=0x10+i, op2=1, ADD then PASS -> 0x11+i
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_fill_rdy", {31'd0, bus.in_ready_o}, 32'd1);
      drive(8'h10 + 8'(k), 8'h01, OP_ADD, OP_PASS);
    end
    @(negedge clk);
    drive(8'h13, 8'h01, OP_ADD, OP_PASS);
    chk("bp_occ3",  {30'd0, bus.occupancy_o}, 32'd3);
    chk("bp_rdy0",  {31'd0, bus.in_ready_o}, 32'd0);
    chk("bp_vld",   {31'd0, bus.out_valid_o}, 32'd1);
    chk("bp_res",   {24'd0, bus.res_o}, 32'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_res", {24'd0, bus.res_o}, 32'h11);
      chk("bp_hold_rdy", {31'd0, bus.in_ready_o}, 32'd0);
      chk("bp_hold_occ", {30'd0, bus.occupancy_o}, 32'd3);
    end
    bus.out_ready_i = 1'b1;
    for (int m = 0; m < 5; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 1) drive(8'h14, 8'h01, OP_ADD, OP_PASS);
      if (m == 2) bus.in_valid_i = 1'b0;
      chk("bp_drain_vld", {31'd0, bus.out_valid_o}, 32'd1);
      chk("bp_drain_res", {24'd0, bus.res_o}, 32'h11 + 32'(m));
      if (m == 1) chk("bp_shift_occ", {30'd0, bus.occupancy_o}, 32'd3);
    end
    @(negedge clk);
    chk("bp_empty", {31'd0, bus.out_valid_o}, 32'd0);

    // 4: wrap and flags
    v_op1[0] = 8'h80; v_op2[0] = 8'h80; v_sa[0] = OP_ADD;  v_sb[0] = OP_SUB; v_exp[0] = 8'h80;
    v_op1[1] = 8'h01; v_op2[1] = 8'h07; v_sa[1] = OP_SLL;  v_sb[1] = OP_SRL; v_exp[1] = 8'h40;
    v_op1[2] = 8'h0F; v_op2[2] = 8'h00; v_sa[2] = OP_PASS; v_sb[2] = OP_SUB; v_exp[2] = 8'h00;
    run_vec("wrap", 3);

    // 5: flush a full pipe; the input offered with the flush must be dropped
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(8'h21 + 8'(k), 8'h02, OP_AND, OP_OR);
    end
    @(negedge clk);
    chk("fl_full", {30'd0, bus.occupancy_o}, 32'd3);
    flush_i = 1'b1;
    drive(8'h55, 8'h55, OP_ADD, OP_ADD);
    #1;
    chk("fl_rdy0", {31'd0, bus.in_ready_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl_vld", {31'd0, bus.out_valid_o}, 32'd0);
    chk("fl_occ", {30'd0, bus.occupancy_o}, 32'd0);
    bus.out_ready_i = 1'b1;
    v_op1[0] = 8'h09; v_op2[0] = 8'h04; v_sa[0] = OP_SUB; v_sb[0] = OP_ADD; v_exp[0] = 8'h0E;
    run_vec("post_flush", 1);

    // 6: asynchronous reset mid-stream, between clock edges
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("ar_pre_vld", {31'd0, bus.out_valid_o}, 32'd1);
        chk("ar_pre_res", {24'd0, bus.res_o}, 32'h41);
      end
      drive(8'h40, 8'h01, OP_ADD, OP_OR);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vld",  {31'd0, bus.out_valid_o}, 32'd0);
    chk("ar_res",  {24'd0, bus.res_o}, 32'd0);
    chk("ar_occ",  {30'd0, bus.occupancy_o}, 32'd0);
    chk("ar_zero", {31'd0, bus.zero_o}, 32'd0);
    chk("ar_rdy",  {31'd0, bus.in_ready_o}, 32'd0);
    bus.in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    v_op1[0] = 8'h33; v_op2[0] = 8'h11; v_sa[0] = OP_OR; v_sb[0] = OP_SRL; v_exp[0] = 8'h06;
    run_vec("post_rst", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
